// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: size/state encodings and access-check helpers
package dmem_responder_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    return size == SZ_B ? 8'h01 : size == SZ_H ? 8'h03 : size == SZ_W ? 8'h0f : 8'hff;
  endfunction
  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
    return size == SZ_B ? 1'b0 : size == SZ_H ? off[0] : size == SZ_W ? |off[1:0] : |off;
  endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: little-endian store merge and load extract/extend
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [2:0]  off,
  input  logic        is_unsigned,
  input  logic [63:0] wdata,
  input  logic [63:0] rword,
  output logic [63:0] merged,
  output logic [63:0] load_data
);
  logic [7:0]  be;
  logic [63:0] bmask;
  logic [63:0] wsh;
  logic [63:0] rsh;
  logic        sx;
  for (genvar i = 0; i < 8; i++) begin : g_mask
    assign bmask[i*8 +: 8] = {8{be[i]}};
  end
  always_comb begin
    be = 8'(size_mask(size) << off);
    wsh = wdata << {off, 3'b000};
    rsh = rword >> {off, 3'b000};
    merged = (rword & ~bmask) | (wsh & bmask);
    sx = ~is_unsigned;
    load_data = size == SZ_B ? {{56{sx & rsh[7]}}, rsh[7:0]} :
                size == SZ_H ? {{48{sx & rsh[15]}}, rsh[15:0]} :
                size == SZ_W ? {{32{sx & rsh[31]}}, rsh[31:0]} : rsh;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with programmable latency
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [63:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [2:0]    off_q, off_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic          rv_q, rv_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          rerr_q, rerr_d;
  logic [63:0]   mem [DEPTH];
  logic [63:0]   rword, merged, load_data;
  logic          accept, fire, done, mem_we;
  assign req_ready = (state_q == ST_IDLE) & ~rst;
  assign rsp_valid = rv_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;
  assign rword     = mem[idx_q];
  dmem_lane_align u_align (
    .size        (size_q),
    .off         (off_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rword       (rword),
    .merged      (merged),
    .load_data   (load_data)
  );
  // The access edge is the last WAIT cycle; the counter is loaded with LATENCY so WAIT spans LATENCY+1 cycles.
  always_comb begin
    accept  = req_valid & req_ready;
    fire    = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    done    = (state_q == ST_RESP) && rsp_ready;
    mem_we  = fire & we_q & ~err_q;
    state_d = accept ? ST_WAIT : fire ? ST_RESP : done ? ST_IDLE : state_q;
    cnt_d   = accept ? 4'(LATENCY) : (state_q == ST_WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    we_d    = accept ? req_we : we_q;
    idx_d   = accept ? req_addr[3 +: IW] : idx_q;
    off_d   = accept ? req_addr[2:0] : off_q;
    size_d  = accept ? req_size : size_q;
    uns_d   = accept ? req_unsigned : uns_q;
    wdata_d = accept ? req_wdata : wdata_q;
    err_d   = accept ? (misaligned(req_addr[2:0], req_size) | ((req_addr >> 3) >= ADDR_W'(DEPTH))) : err_q;
    rv_d    = fire ? 1'b1 : done ? 1'b0 : rv_q;
    rdata_d = fire ? ((we_q | err_q) ? 64'd0 : load_data) : rdata_q;
    rerr_d  = fire ? err_q : rerr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      off_q   <= 3'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      wdata_q <= 64'd0;
      err_q   <= 1'b0;
      rv_q    <= 1'b0;
      rdata_q <= 64'd0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= merged;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of timing, lanes, errors, backpressure and reset
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_wdata = 64'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [63:0] wd);
    int n;
    n = 0;
    @(negedge clk);
    req_we = we;
    req_addr = addr;
    req_size = size;
    req_unsigned = uns;
    req_wdata = wd;
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [63:0] wd,
                      output int lat, output logic [63:0] rd, output logic er);
    issue(we, addr, size, uns, wd);
    lat = 0;
    while (!rsp_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!rsp_valid) begin
      tests++;
      fails++;
      $display("FAIL timeout addr=%h: no rsp_valid within 30 cycles", addr);
    end
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #10;
    tests++;
    if ({rsp_valid, rsp_err, req_ready} !== 3'b000 || rsp_rdata !== 64'd0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b err=%b ready=%b rdata=%h, need all 0",
               rsp_valid, rsp_err, req_ready, rsp_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b need 1", req_ready);
    end
  endtask

  task automatic test_store_load;
    int lat;
    logic [63:0] rd;
    logic er;
    xact(1'b1, 32'h10, 2'd3, 1'b0, 64'h8877665544332211, lat, rd, er);
    tests++;
    if (lat !== 3 || er !== 1'b0 || rd !== 64'd0) begin
      fails++;
      $display("FAIL sd_timing: lat=%0d err=%b rdata=%h need lat=3 err=0 rdata=0", lat, er, rd);
    end
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL sd_release: valid=%b ready=%b need 0 1", rsp_valid, req_ready);
    end
    xact(1'b0, 32'h10, 2'd3, 1'b0, 64'd0, lat, rd, er);
    tests++;
    if (lat !== 3 || er !== 1'b0 || rd !== 64'h8877665544332211) begin
      fails++;
      $display("FAIL ld_0x10: lat=%0d err=%b rdata=%h need 3 0 8877665544332211", lat, er, rd);
    end
  endtask

  task automatic test_extend;
    logic [31:0] addr [6] = '{32'h17, 32'h17, 32'h12, 32'h14, 32'h14, 32'h16};
    logic [1:0]  size [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd1};
    logic        uns  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [63:0] exp  [6] = '{64'hFFFF_FFFF_FFFF_FF88, 64'h88, 64'h4433,
                              64'hFFFF_FFFF_8877_6655, 64'h8877_6655, 64'hFFFF_FFFF_FFFF_8877};
    int lat;
    logic [63:0] rd;
    logic er;
    for (int i = 0; i < 6; i++) begin
      xact(1'b0, addr[i], size[i], uns[i], 64'd0, lat, rd, er);
      tests++;
      if (rd !== exp[i] || er !== 1'b0) begin
        fails++;
        $display("FAIL extend_%0d addr=%h: rdata=%h err=%b need %h 0", i, addr[i], rd, er, exp[i]);
      end
    end
  endtask

  task automatic test_partial_store;
    int lat;
    logic [63:0] rd;
    logic er;
    xact(1'b1, 32'h11, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFAA, lat, rd, er);
    tests++;
    if (er !== 1'b0) begin
      fails++;
      $display("FAIL sb_err: got %b need 0", er);
    end
    xact(1'b0, 32'h10, 2'd3, 1'b0, 64'd0, lat, rd, er);
    tests++;
    if (rd !== 64'h8877_6655_4433_AA11) begin
      fails++;
      $display("FAIL sb_merge: rdata=%h need 887766554433aa11", rd);
    end
  endtask

  task automatic test_errors;
    int lat;
    logic [63:0] rd;
    logic er;
    xact(1'b1, 32'h0, 2'd3, 1'b0, 64'h0102030405060708, lat, rd, er);
    xact(1'b0, 32'h12, 2'd2, 1'b0, 64'd0, lat, rd, er);
    tests++;
    if (er !== 1'b1 || rd !== 64'd0 || lat !== 3) begin
      fails++;
      $display("FAIL lw_misaligned: err=%b rdata=%h lat=%0d need 1 0 3", er, rd, lat);
    end
    xact(1'b1, 32'h800, 2'd3, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF, lat, rd, er);
    tests++;
    if (er !== 1'b1 || rd !== 64'd0 || lat !== 3) begin
      fails++;
      $display("FAIL sd_range: err=%b rdata=%h lat=%0d need 1 0 3", er, rd, lat);
    end
    xact(1'b1, 32'h12, 2'd2, 1'b0, 64'hCAFE_CAFE_CAFE_CAFE, lat, rd, er);
    tests++;
    if (er !== 1'b1) begin
      fails++;
      $display("FAIL sw_misaligned: err=%b need 1", er);
    end
    xact(1'b0, 32'h10, 2'd3, 1'b0, 64'd0, lat, rd, er);
    tests++;
    if (rd !== 64'h8877_6655_4433_AA11 || er !== 1'b0) begin
      fails++;
      $display("FAIL err_nowrite_0x10: rdata=%h err=%b need 887766554433aa11 0", rd, er);
    end
    xact(1'b0, 32'h0, 2'd3, 1'b0, 64'd0, lat, rd, er);
    tests++;
    if (rd !== 64'h0102030405060708) begin
      fails++;
      $display("FAIL err_nowrite_0x0: rdata=%h need 0102030405060708", rd);
    end
  endtask

  task automatic test_backpressure;
    int n;
    issue(1'b0, 32'h10, 2'd3, 1'b0, 64'd0);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 32'h18;
    n = 0;
    while (!rsp_valid && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      tests++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h8877_6655_4433_AA11 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_%0d: valid=%b rdata=%h err=%b ready=%b need 1 887766554433aa11 0 0",
                 c, rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_release: valid=%b ready=%b need 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [63:0] rd;
    logic er;
    xact(1'b1, 32'h20, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, lat, rd, er);
    issue(1'b1, 32'h20, 2'd3, 1'b0, 64'hDEAD_DEAD_DEAD_DEAD);
    @(posedge clk);
    #1 rst = 1'b1;
    #3;
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_outputs: valid=%b ready=%b need 0 0", rsp_valid, req_ready);
    end
    rst = 1'b0;
    xact(1'b0, 32'h20, 2'd3, 1'b0, 64'd0, lat, rd, er);
    tests++;
    if (rd !== 64'h0123_4567_89AB_CDEF) begin
      fails++;
      $display("FAIL mid_reset_nowrite: rdata=%h need 0123456789abcdef", rd);
    end
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_extend;
    test_partial_store;
    test_errors;
    test_backpressure;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
